// File: rtl/conv2d_systolic_stream.sv
// Streaming KxK convolution over an IMGxIMG image: serial filter load, line-buffered sliding window, 2-cycle result pipeline.
// Optional output saturation when CONV_SATURATE_EN is defined; otherwise results wrap to DATA_W bits.
module conv2d_systolic_stream #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int IMG    = 4,
    localparam int OUT_N = IMG - K + 1,
    localparam int IDX_W = (OUT_N * OUT_N > 1) ? $clog2(OUT_N * OUT_N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              filt_valid,
    input  logic [DATA_W-1:0] filt_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done
);
    localparam int NC    = K * K;
    localparam int CW    = $clog2(IMG);
    localparam int PW    = $clog2(IMG * IMG);
    localparam int FW    = $clog2(NC);
    localparam int PRD_W = 2 * DATA_W;
    localparam int ACC_W = 2 * DATA_W + $clog2(NC);
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
`ifdef CONV_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_F = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state_r, state_nx;

    logic [FW-1:0]     fcnt_r;
    logic [PW-1:0]     pcnt_r;
    logic [CW-1:0]     row_r, col_r;
    logic              dcnt_r;
    logic [IDX_W-1:0]  res_cnt_r;
    logic [DATA_W-1:0] filt_r [NC];
    logic [DATA_W-1:0] lb_r   [K-1][IMG];
    logic [DATA_W-1:0] win_r  [K][K];
    logic [DATA_W-1:0] col_s  [K];
    logic [PRD_W-1:0]  prod_r [NC];
    logic              win_vld_r, p_vld_r;
    logic              pix_acc_s;
    logic [ACC_W-1:0]  sum_s;
    logic [DATA_W-1:0] res_s;

    assign pix_acc_s = pix_valid & pix_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (start) state_nx = LOAD_F; else state_nx = IDLE;
            LOAD_F:  if (filt_valid && fcnt_r == FW'(NC - 1)) state_nx = STREAM; else state_nx = LOAD_F;
            STREAM:  if (pix_acc_s && pcnt_r == PW'(IMG * IMG - 1)) state_nx = DRAIN; else state_nx = STREAM;
            DRAIN:   if (dcnt_r) state_nx = DONE; else state_nx = DRAIN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Run counters: coefficient, pixel position, drain and result index
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_r    <= '0;
            pcnt_r    <= '0;
            row_r     <= '0;
            col_r     <= '0;
            dcnt_r    <= 1'b0;
            res_cnt_r <= '0;
        end else begin
            if (state_r == IDLE && start) begin
                fcnt_r    <= '0;
                pcnt_r    <= '0;
                row_r     <= '0;
                col_r     <= '0;
                res_cnt_r <= '0;
            end else begin
                if (state_r == LOAD_F && filt_valid) fcnt_r <= fcnt_r + FW'(1);
                if (pix_acc_s) begin
                    pcnt_r <= pcnt_r + PW'(1);
                    if (col_r == CW'(IMG - 1)) begin
                        col_r <= '0;
                        row_r <= (row_r == CW'(IMG - 1)) ? '0 : row_r + CW'(1);
                    end else begin
                        col_r <= col_r + CW'(1);
                    end
                end
                if (p_vld_r) res_cnt_r <= res_cnt_r + IDX_W'(1);
            end
            dcnt_r <= (state_r == DRAIN) ? ~dcnt_r : 1'b0;
        end
    end

    // Filter coefficient store, refilled on every run
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) filt_r[i] <= '0;
        end else if (state_r == LOAD_F && filt_valid) begin
            filt_r[fcnt_r] <= filt_data;
        end
    end

    // Column tap: rows r-K+1..r-1 from the line buffers, row r from the incoming pixel
    always_comb begin
        for (int i = 0; i < K - 1; i++) col_s[i] = lb_r[i][col_r];
        col_s[K-1] = pix_data;
    end

    // Line buffers shift up one row per column; the window shifts left by one column
    always_ff @(posedge clk) begin
        if (pix_acc_s) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) win_r[i][j] <= win_r[i][j+1];
                win_r[i][K-1] <= col_s[i];
            end
            for (int i = 0; i < K - 1; i++) lb_r[i][col_r] <= col_s[i+1];
        end
    end

    // Product stage
    always_ff @(posedge clk) begin
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                prod_r[i*K+j] <= PRD_W'(win_r[i][j]) * PRD_W'(filt_r[i*K+j]);
    end

    // Reduction and output word selection
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NC; i++) sum_s = sum_s + ACC_W'(prod_r[i]);
        if (SAT_EN && sum_s > SAT_MAX) res_s = {DATA_W{1'b1}};
        else                           res_s = sum_s[DATA_W-1:0];
    end

    // Registered status, handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_ready <= 1'b0;
            win_vld_r <= 1'b0;
            p_vld_r   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
            pix_ready <= (state_nx == STREAM);
            win_vld_r <= pix_acc_s && row_r >= CW'(K - 1) && col_r >= CW'(K - 1);
            p_vld_r   <= win_vld_r;
            out_valid <= p_vld_r;
            if (p_vld_r) begin
                out_data <= res_s;
                out_idx  <= res_cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_conv2d_systolic_stream.sv
// Self-checking bench: default (K=3, IMG=4) and small (K=2, IMG=3) instances against a direct-convolution reference.
module tb_conv2d_systolic_stream;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst, start1, start2, filt_valid, pix_valid;
    logic [DW-1:0] filt_data, pix_data;
    logic          pr1, ov1, busy1, done1;
    logic [DW-1:0] od1;
    logic [3:0]    oi1;
    logic          pr2, ov2, busy2, done2;
    logic [DW-1:0] od2;
    logic [1:0]    oi2;

    conv2d_systolic_stream #(.DATA_W(DW), .K(3), .IMG(4)) u_dut (
        .clk(clk), .rst(rst), .start(start1), .filt_valid(filt_valid), .filt_data(filt_data),
        .pix_valid(pix_valid), .pix_ready(pr1), .pix_data(pix_data), .out_valid(ov1),
        .out_data(od1), .out_idx(oi1), .busy(busy1), .done(done1));

    conv2d_systolic_stream #(.DATA_W(DW), .K(2), .IMG(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .filt_valid(filt_valid), .filt_data(filt_data),
        .pix_valid(pix_valid), .pix_ready(pr2), .pix_data(pix_data), .out_valid(ov2),
        .out_data(od2), .out_idx(oi2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int got_d[$], got_i[$], got_c[$];
    int n_done = 0;
    int filt_q[$], img_q[$];
    int last_base;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (ov1) begin got_d.push_back(int'(od1)); got_i.push_back(int'(oi1)); got_c.push_back(cyc); end
        if (ov2) begin got_d.push_back(int'(od2)); got_i.push_back(int'(oi2)); got_c.push_back(cyc); end
        if (done1 || done2) n_done++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int conv_ref(input int kk, input int nn, input int oi);
        int on, r0, c0, s;
        on = nn - kk + 1;
        r0 = oi / on;
        c0 = oi % on;
        s  = 0;
        for (int i = 0; i < kk; i++)
            for (int j = 0; j < kk; j++)
                s += filt_q[i*kk+j] * img_q[(r0+i)*nn + c0 + j];
`ifdef CONV_SATURATE_EN
        return (s > 255) ? 255 : s;
`else
        return s % 256;
`endif
    endfunction

    task automatic do_run(input int sel, input int kk, input int nn, input bit gap,
                          input bit misuse, input int stop_at);
        int k, p, g, b_out, b_done, on, nexp, n_got;
        int ec[$];
        bit v;
        b_out = got_d.size();
        b_done = n_done;
        last_base = b_out;
        @(negedge clk);
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        k = 0; g = 0;
        while (k < kk*kk && g < 500) begin
            v = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            filt_valid = v;
            filt_data  = DW'(filt_q[k]);
            if (v) k++;
            @(negedge clk); g++;
        end
        filt_valid = 1'b0;
        check("filt_loaded", k, kk*kk);
        p = 0;
        while (p < stop_at && g < 2000) begin
            v = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_valid = v;
            pix_data  = DW'(img_q[p]);
            if (misuse) begin
                start1     = (sel == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                start2     = (sel == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                filt_valid = 1'($urandom_range(0, 1));
                filt_data  = DW'($urandom_range(0, 255));
            end
            if (v && (sel == 1 ? pr1 : pr2)) begin
                if (p / nn >= kk - 1 && p % nn >= kk - 1) ec.push_back(cyc + 3);
                p++;
            end
            @(negedge clk); g++;
        end
        pix_valid = 1'b0; start1 = 1'b0; start2 = 1'b0; filt_valid = 1'b0;
        check("pix_accepted", p, stop_at);
        if (stop_at < nn*nn) return;
        g = 0;
        while (n_done == b_done && g < 40) begin @(negedge clk); g++; end
        repeat (3) @(negedge clk);
        on = nn - kk + 1;
        nexp = on * on;
        n_got = got_d.size() - b_out;
        check("done_pulses", n_done - b_done, 1);
        check("n_results", n_got, nexp);
        check("busy_after", int'(sel == 1 ? busy1 : busy2), 0);
        for (int i = 0; i < nexp && i < n_got; i++) begin
            check("out_data", got_d[b_out+i], conv_ref(kk, nn, i));
            check("out_idx", got_i[b_out+i], i);
            check("latency", got_c[b_out+i], ec[i]);
        end
    endtask

    task automatic spec_chk(input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++)
            if (last_base + i < got_d.size()) check("spec_val", got_d[last_base+i], e[i]);
            else check("spec_present", 0, 1);
    endtask

    task automatic load_test1();
        filt_q = '{3, 2, 0, 2, 0, 1, 3, 1, 1};
        img_q  = '{9, 8, 2, 6, 0, 4, 1, 6, 4, 10, 1, 1, 2, 2, 9, 9};
    endtask

    initial begin
        int b, bd;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; filt_valid = 1'b0; pix_valid = 1'b0;
        filt_data = '0; pix_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_ready", int'(pr1), 0);
        check("rst_valid", int'(ov1), 0);
        check("rst_data", int'(od1), 0);
        check("rst_idx", int'(oi1), 0);

        load_test1();
        do_run(1, 3, 4, 1'b0, 1'b0, 16);
        spec_chk(67, 74, 34, 59);
        do_run(1, 3, 4, 1'b1, 1'b0, 16);
        spec_chk(67, 74, 34, 59);
        do_run(1, 3, 4, 1'b0, 1'b1, 16);
        spec_chk(67, 74, 34, 59);

        do_run(1, 3, 4, 1'b0, 1'b0, 10);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        b = got_d.size(); bd = n_done;
        repeat (12) @(negedge clk);
        check("abort_out", got_d.size() - b, 0);
        check("abort_done", n_done - bd, 0);
        check("abort_busy", int'(busy1), 0);
        do_run(1, 3, 4, 1'b0, 1'b0, 16);
        spec_chk(67, 74, 34, 59);

        filt_q.delete(); img_q.delete();
        for (int i = 0; i < 9; i++) filt_q.push_back(255);
        for (int i = 0; i < 16; i++) img_q.push_back(255);
        do_run(1, 3, 4, 1'b1, 1'b0, 16);
`ifdef CONV_SATURATE_EN
        spec_chk(255, 255, 255, 255);
`else
        spec_chk(9, 9, 9, 9);
`endif

        for (int t = 0; t < 4; t++) begin
            filt_q.delete(); img_q.delete();
            for (int i = 0; i < 9; i++) filt_q.push_back($urandom_range(0, 255));
            for (int i = 0; i < 16; i++) img_q.push_back($urandom_range(0, 255));
            do_run(1, 3, 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16);
        end

        filt_q = '{1, 1, 1, 1};
        img_q  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        do_run(2, 2, 3, 1'b0, 1'b0, 9);
        spec_chk(12, 16, 24, 28);
        filt_q.delete(); img_q.delete();
        for (int i = 0; i < 4; i++) filt_q.push_back($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) img_q.push_back($urandom_range(0, 255));
        do_run(2, 2, 3, 1'b1, 1'b1, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv2d_systolic_stream.md
Name: conv2d_systolic_stream

Overview:
- Parametrised, streaming successor to the fixed 3x3-filter / 4x4-image systolic convolution block.
- Loads a KxK filter serially, then accepts an IMGxIMG image one pixel per cycle in row-major order.
- Builds the sliding window with K-1 line buffers plus a KxK window register array, and emits the valid (no-padding, stride 1) convolution results as a row-major stream.
- Sits between the pixel source and the downstream result sink in the convolution datapath.

Parameters:
- DATA_W, 8: width of pixel, filter coefficient and output words (unsigned).
- K, 3: filter edge length. Legal range is 2 <= K <= IMG.
- IMG, 4: image edge length. Output edge length is OUT_N = IMG-K+1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- filt_valid  in  1  filter word present on filt_data
- filt_data  in  DATA_W  filter coefficient, row-major f[0][0]..f[K-1][K-1]
- pix_valid  in  1  pixel present on pix_data
- pix_ready  out  1  block accepts a pixel this cycle
- pix_data  in  DATA_W  image pixel, row-major
- out_valid  out  1  out_data/out_idx valid this cycle (one-cycle pulse per result)
- out_data  out  DATA_W  convolution result
- out_idx  out  clog2(OUT_N*OUT_N) (min 1)  row-major index of result
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: all state is cleared on a clk edge with rst=1. FSM goes to IDLE. pix_ready, out_valid, out_data, out_idx, busy and done are all 0. Filter registers and all counters are 0. Line-buffer contents are don't-care.
- FSM states: IDLE, LOAD_F, STREAM, DRAIN, DONE.
- IDLE: start=1 moves to LOAD_F. start is ignored in every other state.
- LOAD_F:
  - Each cycle with filt_valid=1 stores filt_data at the next coefficient position; idle cycles are allowed.
  - After the K*K-th word, the FSM moves to STREAM.
  - The filter is reloaded on every run.
- STREAM:
  - pix_ready=1 only in this state. A pixel is accepted when pix_valid & pix_ready; gaps are allowed.
  - Column and row counters advance on each acceptance and wrap at IMG.
  - After IMG*IMG pixels are accepted, pix_ready drops in the following cycle and the FSM moves to DRAIN.
- Window completion: an accepted pixel at (r,c) with r>=K-1 and c>=K-1 completes the window whose top-left is (r-K+1, c-K+1). The window is never formed across a row wrap.
- Latency and pipeline:
  - The accepting edge is N. At edge N+1 the K*K products are registered. At edge N+2 the sum, out_data and out_idx are registered and out_valid=1 for exactly one cycle.
  - This latency is fixed at 2 cycles and is independent of K.
- Throughput: one result per accepted completing pixel. There is no output backpressure; the sink must accept every pulse.
- DRAIN: waits 2 cycles so the last result emerges, then moves to DONE.
- DONE: done=1 for one cycle, then the FSM returns to IDLE with busy=0.
- Arithmetic:
  - Products are unsigned, DATA_W x DATA_W gives 2*DATA_W bits.
  - The accumulator is 2*DATA_W + clog2(K*K) bits, so it never overflows.
  - Output reduction is defined under Optional Feature.
- out_idx: counts 0..OUT_N*OUT_N-1 within a run and resets to 0 at the start of each run. out_data and out_idx hold their last values when out_valid=0.
- Reset mid-operation: rst in any state aborts the run. There is no done pulse, and any in-flight pipeline results are discarded (out_valid stays 0).
- Filter/pixel interface misuse: filt_valid outside LOAD_F is ignored. pix_valid outside STREAM is ignored (pix_ready=0).

Optional Feature:
- Macro: CONV_SATURATE_EN.
- Defined: out_data = min(sum, 2^DATA_W - 1), i.e. unsigned saturation.
- Undefined: out_data = sum[DATA_W-1:0], i.e. truncation (wrap).

Test Plan:
- Default parameters, filter 3,2,0,2,0,1,3,1,1, image 9,8,2,6,0,4,1,6,4,10,1,1,2,2,9,9 -> four pulses, out_data 67,74,34,59 with out_idx 0,1,2,3. done pulses once; busy is 0 afterwards.
- Same stimulus with pix_valid toggling 1-0-1-0 -> identical results. Each out_valid appears exactly 2 cycles after the accepting edge of the window's bottom-right pixel.
- Filter all 255, image all 255:
  - without CONV_SATURATE_EN -> all outputs 9 (585225 mod 256);
  - with it -> all outputs 255.
- rst asserted for 1 cycle mid-STREAM after 10 pixels -> no further out_valid and no done. Then start and rerun the first test -> 67,74,34,59.
- Start pulsed during STREAM and filt_valid asserted during STREAM -> ignored; results are unchanged.
- K=2, IMG=3, filter 1,1,1,1, image 1..9 -> 4 results: 12,16,24,28.
